// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with a request/ready memory port,
// a one-entry skid buffer behind the IF/ID register, redirect (flush) and
// halt handling. States: FETCH (issue), WAIT (hold request until ready),
// HALTED (idle until reset).
// Optional build macro FETCH_PERF_CNT_EN adds the fetch_count output, which
// counts instructions loaded into IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {FETCH, WAIT, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] wait_addr_q, wait_addr_d;   // address held on the port in WAIT
    logic        discard_q, discard_d;       // outstanding response must be dropped
    logic        halt_pend_q, halt_pend_d;   // halt seen while a response is outstanding
    logic        buf_vld_q, buf_vld_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic        req;
    logic [31:0] addr;
    logic        load;                       // a real instruction enters IF/ID

    // Next-state, memory request and IF/ID/buffer update logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wait_addr_d = wait_addr_q;
        discard_d   = discard_q;
        halt_pend_d = halt_pend_q;
        buf_vld_d   = buf_vld_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        if_valid_d  = if_valid_q;
        req         = 1'b0;
        addr        = pc_q;
        load        = 1'b0;

        case (state_q)
            FETCH: begin
                if (halt) begin
                    state_d    = HALTED;
                    buf_vld_d  = 1'b0;
                    if_instr_d = 32'h0;
                    if_valid_d = 1'b0;
                end else begin
                    // A full buffer drains whenever stall is low, so it is
                    // always free again by the time a new response lands.
                    req = !stall;
                    if (flush) begin
                        pc_d       = redirect_pc;
                        buf_vld_d  = 1'b0;
                        if_instr_d = 32'h0;
                        if_valid_d = 1'b0;
                        if (req && !imem_ready) begin
                            state_d     = WAIT;
                            wait_addr_d = pc_q;
                            discard_d   = 1'b1;
                        end
                    end else if (!stall) begin
                        if (buf_vld_q) begin
                            if_instr_d = buf_instr_q;
                            if_pc_d    = buf_pc_q;
                            if_valid_d = 1'b1;
                            buf_vld_d  = 1'b0;
                            load       = 1'b1;
                        end
                        if (imem_ready) begin
                            pc_d = pc_q + 32'd4;
                            if (buf_vld_q) begin
                                buf_instr_d = imem_rdata;
                                buf_pc_d    = pc_q;
                                buf_vld_d   = 1'b1;
                            end else begin
                                if_instr_d = imem_rdata;
                                if_pc_d    = pc_q;
                                if_valid_d = 1'b1;
                                load       = 1'b1;
                            end
                        end else begin
                            state_d     = WAIT;
                            wait_addr_d = pc_q;
                            discard_d   = 1'b0;
                        end
                    end
                end
            end
            WAIT: begin
                req  = 1'b1;
                addr = wait_addr_q;
                if (halt) begin
                    halt_pend_d = 1'b1;
                    discard_d   = 1'b1;
                end else if (flush) begin
                    pc_d       = redirect_pc;
                    discard_d  = 1'b1;
                    buf_vld_d  = 1'b0;
                    if_instr_d = 32'h0;
                    if_valid_d = 1'b0;
                end
                if (imem_ready) begin
                    discard_d   = 1'b0;
                    halt_pend_d = 1'b0;
                    if (halt || halt_pend_q) begin
                        state_d    = HALTED;
                        buf_vld_d  = 1'b0;
                        if_instr_d = 32'h0;
                        if_valid_d = 1'b0;
                    end else begin
                        state_d = FETCH;
                        if (!discard_q && !flush) begin
                            pc_d = wait_addr_q + 32'd4;
                            if (stall) begin
                                buf_instr_d = imem_rdata;
                                buf_pc_d    = wait_addr_q;
                                buf_vld_d   = 1'b1;
                            end else begin
                                if_instr_d = imem_rdata;
                                if_pc_d    = wait_addr_q;
                                if_valid_d = 1'b1;
                                load       = 1'b1;
                            end
                        end
                    end
                end
            end
            HALTED: begin
                buf_vld_d  = 1'b0;
                if_instr_d = 32'h0;
                if_valid_d = 1'b0;
            end
            default: state_d = FETCH;
        endcase
    end

    // State, PC, buffer and IF/ID registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            wait_addr_q <= RESET_PC;
            discard_q   <= 1'b0;
            halt_pend_q <= 1'b0;
            buf_vld_q   <= 1'b0;
            buf_instr_q <= 32'h0;
            buf_pc_q    <= RESET_PC;
            if_instr_q  <= 32'h0;
            if_pc_q     <= RESET_PC;
            if_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wait_addr_q <= wait_addr_d;
            discard_q   <= discard_d;
            halt_pend_q <= halt_pend_d;
            buf_vld_q   <= buf_vld_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            if_valid_q  <= if_valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;

    // Count every real instruction entering IF/ID; wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_count_q <= 32'h0;
        else if (load) fetch_count_q <= fetch_count_q + 32'd1;
    end

    assign fetch_count = fetch_count_q;
`else
    logic unused_load;
    assign unused_load = load;
`endif

    // The request is suppressed while reset is held, even though FETCH is entered
    assign imem_req  = req && !rst;
    assign imem_addr = addr;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table with a scoreboard queue, plus
// hand-written asynchronous reset sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, halt, imem_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr, if_instr, if_pc;
    logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, fl;
        logic [31:0] rpc;
        logic        ht, rdy;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc, einstr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic logic [31:0] D(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    function automatic vec_t V(input logic st, input logic fl, input logic [31:0] rpc,
                               input logic ht, input logic rdy, input logic [31:0] rdata,
                               input logic ereq, input logic [31:0] eaddr, input logic evld,
                               input logic [31:0] epc, input logic [31:0] einstr);
        vec_t v;
        v.st = st; v.fl = fl; v.rpc = rpc; v.ht = ht; v.rdy = rdy; v.rdata = rdata;
        v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc; v.einstr = einstr;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one row after the edge, compare at the falling edge, move to next edge
    task automatic apply(input int idx);
        vec_t v, e;
        v = tbl[idx];
        stall = v.st; flush = v.fl; redirect_pc = v.rpc; halt = v.ht;
        imem_ready = v.rdy; imem_rdata = v.rdata;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        check("imem_req", idx, {31'h0, imem_req}, {31'h0, e.ereq});
        if (e.ereq) check("imem_addr", idx, imem_addr, e.eaddr);
        check("if_valid", idx, {31'h0, if_valid}, {31'h0, e.evld});
        check("if_instr", idx, if_instr, e.einstr);
        if (e.evld) check("if_pc", idx, if_pc, e.epc);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   -1, {31'h0, imem_req}, 32'h0);
        check({tag, "_valid"}, -1, {31'h0, if_valid}, 32'h0);
        check({tag, "_instr"}, -1, if_instr, 32'h0);
        check({tag, "_pc"},    -1, if_pc, 32'h0);
    endtask

    initial begin
        // Sequence 1: streaming, wait states, stall buffering, flushes, halt
        tbl.push_back(V(0,0,0,0,1,D(0),        1,32'h0,  0,0,0));
        tbl.push_back(V(0,0,0,0,1,D(4),        1,32'h4,  1,32'h0,D(0)));
        tbl.push_back(V(0,0,0,0,0,0,           1,32'h8,  1,32'h4,D(4)));
        tbl.push_back(V(0,0,0,0,0,0,           1,32'h8,  1,32'h4,D(4)));
        tbl.push_back(V(0,0,0,0,0,0,           1,32'h8,  1,32'h4,D(4)));
        tbl.push_back(V(0,0,0,0,1,D(8),        1,32'h8,  1,32'h4,D(4)));
        tbl.push_back(V(0,0,0,0,1,D(32'hC),    1,32'hC,  1,32'h8,D(8)));
        tbl.push_back(V(0,0,0,0,0,0,           1,32'h10, 1,32'hC,D(32'hC)));
        tbl.push_back(V(1,0,0,0,1,32'hDEADBEEF,1,32'h10, 1,32'hC,D(32'hC)));
        tbl.push_back(V(1,0,0,0,0,0,           0,0,      1,32'hC,D(32'hC)));
        tbl.push_back(V(0,0,0,0,0,0,           1,32'h14, 1,32'hC,D(32'hC)));
        tbl.push_back(V(0,0,0,0,1,D(32'h14),   1,32'h14, 1,32'h10,32'hDEADBEEF));
        tbl.push_back(V(0,0,0,0,0,0,           1,32'h18, 1,32'h14,D(32'h14)));
        tbl.push_back(V(0,1,32'h100,0,0,0,     1,32'h18, 1,32'h14,D(32'h14)));
        tbl.push_back(V(0,0,0,0,1,D(32'h18),   1,32'h18, 0,0,0));
        tbl.push_back(V(0,0,0,0,1,D(32'h100),  1,32'h100,0,0,0));
        tbl.push_back(V(0,0,0,0,1,D(32'h104),  1,32'h104,1,32'h100,D(32'h100)));
        tbl.push_back(V(0,1,32'h20,0,1,D(32'h108),1,32'h108,1,32'h104,D(32'h104)));
        tbl.push_back(V(0,0,0,0,1,D(32'h20),   1,32'h20, 0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,           0,0,      1,32'h20,D(32'h20)));
        tbl.push_back(V(1,1,32'h1C,0,0,0,      0,0,      1,32'h20,D(32'h20)));
        tbl.push_back(V(0,0,0,0,1,D(32'h1C),   1,32'h1C, 0,0,0));
        tbl.push_back(V(0,1,32'h300,1,1,D(32'h20),0,0,   1,32'h1C,D(32'h1C)));
        tbl.push_back(V(0,0,0,0,1,0,           0,0,      0,0,0));
        tbl.push_back(V(0,1,0,0,1,0,           0,0,      0,0,0));
        tbl.push_back(V(0,0,0,0,1,0,           0,0,      0,0,0));
        // Sequence 2a (rows 26-27): fetch then enter WAIT at 0x4
        tbl.push_back(V(0,0,0,0,1,D(0),        1,32'h0,  0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,           1,32'h4,  1,32'h0,D(0)));
        // Sequence 2b (rows 28-33): restart at RESET_PC, halt during WAIT
        tbl.push_back(V(0,0,0,0,1,D(0),        1,32'h0,  0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,           1,32'h4,  1,32'h0,D(0)));
        tbl.push_back(V(0,0,0,1,0,0,           1,32'h4,  1,32'h0,D(0)));
        tbl.push_back(V(0,0,0,0,1,D(4),        1,32'h4,  1,32'h0,D(0)));
        tbl.push_back(V(0,0,0,0,1,0,           0,0,      0,0,0));
        tbl.push_back(V(0,0,0,0,1,0,           0,0,      0,0,0));

        rst = 1'b1; stall = 0; flush = 0; halt = 0; imem_ready = 0;
        redirect_pc = 0; imem_rdata = 0;
        @(negedge clk);
        check_reset_outputs("reset");
`ifdef FETCH_PERF_CNT_EN
        check("count_reset", -1, fetch_count, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 26; i++) apply(i);
`ifdef FETCH_PERF_CNT_EN
        check("count_seq1", -1, fetch_count, 32'd10);
`endif

        // Asynchronous reset out of HALTED, no clock edge needed
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst_halted");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 26; i < 28; i++) apply(i);

        // Reset in the middle of a WAIT abandons the transaction
        imem_ready = 1'b0; halt = 1'b0; flush = 1'b0; stall = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst_wait");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 28; i < 34; i++) apply(i);
`ifdef FETCH_PERF_CNT_EN
        check("count_seq2", -1, fetch_count, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
